// File: rtl/ppu_scan_sequencer.sv
// Raster timing and fetch sequencer for the PPU: dot/scanline counters,
// vblank/NMI source, odd-frame dot skip and background/sprite fetch strobes.
module ppu_scan_sequencer #(
   parameter int unsigned LINE_CYCLES = 341,
   parameter int unsigned VIS_LINES   = 240,
   parameter int unsigned POST_LINES  = 1,
   parameter int unsigned VBL_LINES   = 20,
   parameter int unsigned ODD_SKIP    = 1,
   parameter int unsigned EXT_TRIGGER = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rend_en,
   input  logic       new_frame,
   output logic [8:0] cycle,
   output logic [8:0] scan,
   output logic       prerender,
   output logic       vis_line,
   output logic       vblank,
   output logic       vblank_set,
   output logic       odd_frame,
   output logic       px_en,
   output logic       fetch_nt,
   output logic       fetch_at,
   output logic       fetch_pat0,
   output logic       fetch_pat1,
   output logic       load_sr,
   output logic       inc_cx,
   output logic       inc_y,
   output logic       copy_x,
   output logic       copy_y,
   output logic       sp_eval,
   output logic       load_sp_sr
);

   localparam logic [8:0] PRE_LINE  = 9'h1FF;
   localparam logic [8:0] LAST_CYC  = 9'(LINE_CYCLES - 1);
   localparam logic [8:0] SKIP_CYC  = 9'(LINE_CYCLES - 2);
   localparam logic [8:0] LAST_LINE = 9'(VIS_LINES + POST_LINES + VBL_LINES - 1);
   localparam logic [8:0] VBL_LINE  = 9'(VIS_LINES + POST_LINES);
   localparam logic [8:0] VIS_END   = 9'(VIS_LINES);

   logic       rline;
   logic       fwin;
   logic [8:0] cyc_m1;
   logic [2:0] phase;
   logic       skip_now;

   assign prerender = (scan == PRE_LINE);
   assign vis_line  = (scan < VIS_END);
   assign skip_now  = (ODD_SKIP != 0) && prerender && odd_frame && rend_en && (cycle == SKIP_CYC);

   // Dot/line counters with external restart, odd-frame skip and frame wrap/hold
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle     <= 9'd0;
         scan      <= PRE_LINE;
         odd_frame <= 1'b0;
      end else if ((EXT_TRIGGER != 0) && new_frame) begin
         cycle <= 9'd0;
         scan  <= PRE_LINE;
      end else if (skip_now) begin
         cycle     <= 9'd0;
         scan      <= 9'd0;
         odd_frame <= ~odd_frame;
      end else if (cycle == LAST_CYC) begin
         cycle <= 9'd0;
         if (prerender) begin
            scan      <= 9'd0;
            odd_frame <= ~odd_frame;
         end else if (scan == LAST_LINE) begin
            if (EXT_TRIGGER == 0) scan <= PRE_LINE;
         end else begin
            scan <= scan + 9'd1;
         end
      end else begin
         cycle <= cycle + 9'd1;
      end
   end

   // Vblank flag and one-cycle NMI source pulse, decoded from the state being left
   always_ff @(posedge clk) begin
      if (rst) begin
         vblank     <= 1'b0;
         vblank_set <= 1'b0;
      end else begin
         vblank_set <= 1'b0;
         if ((scan == VBL_LINE) && (cycle == 9'd0)) begin
            vblank     <= 1'b1;
            vblank_set <= 1'b1;
         end else if (prerender && (cycle == 9'd0)) begin
            vblank <= 1'b0;
         end
      end
   end

   // Fetch, loopy-v and sprite strobes decoded from the registered position
   always_comb begin
      rline      = (prerender | vis_line) & rend_en;
      cyc_m1     = cycle - 9'd1;
      phase      = cyc_m1[2:0];
      fwin       = ((cycle >= 9'd1) && (cycle <= 9'd256)) ||
                   ((cycle >= 9'd321) && (cycle <= 9'd336));
      fetch_nt   = rline & fwin & (phase == 3'd0);
      fetch_at   = rline & fwin & (phase == 3'd2);
      fetch_pat0 = rline & fwin & (phase == 3'd4);
      fetch_pat1 = rline & fwin & (phase == 3'd6);
      inc_cx     = rline & fwin & (phase == 3'd7);
      load_sr    = rline & (phase == 3'd0) &
                   (((cycle >= 9'd9) && (cycle <= 9'd257)) ||
                    ((cycle >= 9'd329) && (cycle <= 9'd337)));
      inc_y      = rline & (cycle == 9'd256);
      copy_x     = rline & (cycle == 9'd257);
      copy_y     = prerender & rend_en & (cycle >= 9'd280) & (cycle <= 9'd304);
      sp_eval    = rline & (cycle >= 9'd257) & (cycle <= 9'd320);
      load_sp_sr = vis_line & rend_en & (cycle == 9'd320);
      px_en      = vis_line & (cycle >= 9'd1) & (cycle <= 9'd256);
   end

endmodule

// File: tb/tb_ppu_scan_sequencer.sv
// Scoreboard bench for ppu_scan_sequencer: three instances with shortened
// geometry (NTSC-like, PAL-like without skip, external trigger).
module tb_ppu_scan_sequencer;

   localparam int F_CYC = 100, F_SCN = 101;
   localparam int F_PRE = 16, F_VIS = 15, F_VB = 14, F_VS = 13, F_ODD = 12, F_PX = 11;
   localparam int F_NT = 10, F_AT = 9, F_P0 = 8, F_P1 = 7, F_SR = 6, F_CX = 5;
   localparam int F_IY = 4, F_CPX = 3, F_CPY = 2, F_SPE = 1, F_LSP = 0;

   typedef struct {
      int    t;
      int    d;
      int    f;
      int    v;
      string nm;
   } exp_t;

   logic clk = 1'b0;
   logic rst, rst_e, rend_en, new_frame;
   int   tick = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   got, e;
   logic [34:0] obs [3];
   exp_t sb[$];
   int   vq [3][$];

   always #5 clk = ~clk;
   always @(posedge clk) tick <= tick + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [8:0] cyc, scn;
      logic pre, vis, vb, vs, odd, px, nt, at, p0, p1, sr, cx, iy, cpx, cpy, spe, lsp;
      ppu_scan_sequencer #(
         .LINE_CYCLES(341), .VIS_LINES(4), .POST_LINES(1),
         .VBL_LINES(g == 1 ? 5 : 2), .ODD_SKIP(g == 1 ? 0 : 1), .EXT_TRIGGER(g == 2 ? 1 : 0)
      ) u_dut (
         .clk(clk), .rst(g == 2 ? rst_e : rst), .rend_en(g == 2 ? 1'b0 : rend_en),
         .new_frame(new_frame), .cycle(cyc), .scan(scn), .prerender(pre), .vis_line(vis),
         .vblank(vb), .vblank_set(vs), .odd_frame(odd), .px_en(px), .fetch_nt(nt),
         .fetch_at(at), .fetch_pat0(p0), .fetch_pat1(p1), .load_sr(sr), .inc_cx(cx),
         .inc_y(iy), .copy_x(cpx), .copy_y(cpy), .sp_eval(spe), .load_sp_sr(lsp)
      );
      assign obs[g] = {cyc, scn, pre, vis, vb, vs, odd, px, nt, at, p0, p1, sr, cx, iy, cpx, cpy, spe, lsp};
   end

   function automatic int field_val(int d, int f);
      logic [34:0] o;
      o = obs[d];
      if (f == F_CYC) return int'(o[34:26]);
      if (f == F_SCN) return int'(o[25:17]);
      return int'(o[f]);
   endfunction

   function automatic void ex(int d, int base, int n, int f, int v, string nm);
      exp_t x;
      x.t = base + n; x.d = d; x.f = f; x.v = v;
      x.nm = $sformatf("dut%0d_%s@n%0d", d, nm, n);
      sb.push_back(x);
   endfunction

   // Monitor: vblank_set pulses against expected ticks, point expectations by tick
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (obs[d][F_VS]) begin
            n_vec++;
            if (vq[d].size() == 0) begin
               n_err++;
               $display("FAIL vset_unexpected dut%0d at tick %0d", d, tick);
            end else begin
               e = vq[d].pop_front();
               if (e != tick) begin
                  n_err++;
                  $display("FAIL vset_time dut%0d got tick %0d expected tick %0d", d, tick, e);
               end
            end
         end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].t <= tick) begin
            n_vec++;
            got = field_val(sb[i].d, sb[i].f);
            if (sb[i].t != tick || got != sb[i].v) begin
               n_err++;
               $display("FAIL %s got %0d expected %0d (tick %0d)", sb[i].nm, got, sb[i].v, tick);
            end
            sb.delete(i);
         end
      end
   end

   task automatic wait_to(input int t);
      while (tick < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at tick %0d", tick);
      $fatal(1, "watchdog");
   end

   int a, b, ee, e2;

   initial begin
      rst = 1'b1; rst_e = 1'b1; rend_en = 1'b0; new_frame = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // Phase A: rendering off, free-running frames of 8 lines
      @(posedge clk); #1; rst = 1'b0; a = tick;
      ex(0, a, 0, F_CYC, 0, "cycle"); ex(0, a, 0, F_SCN, 511, "scan");
      ex(0, a, 0, F_PRE, 1, "prerender"); ex(0, a, 0, F_VB, 0, "vblank");
      ex(0, a, 0, F_ODD, 0, "odd"); ex(0, a, 0, F_SPE, 0, "sp_eval");
      ex(0, a, 341, F_ODD, 1, "odd"); ex(0, a, 342, F_PX, 1, "px_en"); ex(0, a, 342, F_NT, 0, "nt_off");
      ex(0, a, 2046, F_VB, 0, "vblank"); ex(0, a, 2047, F_VB, 1, "vblank");
      ex(0, a, 2728, F_SCN, 511, "scan"); ex(0, a, 2728, F_VB, 1, "vblank"); ex(0, a, 2728, F_ODD, 1, "odd");
      ex(0, a, 2729, F_VB, 0, "vblank"); ex(0, a, 3069, F_ODD, 0, "odd"); ex(0, a, 3069, F_SCN, 0, "scan");
      ex(0, a, 10290, F_VB, 1, "vblank_pre_rst");
      vq[0].push_back(a + 2047); vq[0].push_back(a + 4775);
      vq[0].push_back(a + 7503); vq[0].push_back(a + 10231);
      vq[1].push_back(a + 2047); vq[1].push_back(a + 5798); vq[1].push_back(a + 9549);
      wait_to(a + 10290);
      // Phase B: mid-vblank reset, then rendering on
      rst = 1'b1; rend_en = 1'b1;
      @(posedge clk); #1; rst = 1'b0; b = tick;
      ex(0, b, 0, F_CYC, 0, "cycle"); ex(0, b, 0, F_SCN, 511, "scan");
      ex(0, b, 0, F_VB, 0, "vblank"); ex(0, b, 0, F_ODD, 0, "odd"); ex(1, b, 0, F_VB, 0, "vblank");
      ex(0, b, 256, F_SPE, 0, "sp_eval"); ex(0, b, 257, F_SPE, 1, "sp_eval");
      ex(0, b, 279, F_CPY, 0, "copy_y"); ex(0, b, 280, F_CPY, 1, "copy_y");
      ex(0, b, 304, F_CPY, 1, "copy_y"); ex(0, b, 305, F_CPY, 0, "copy_y");
      ex(0, b, 320, F_SPE, 1, "sp_eval"); ex(0, b, 320, F_LSP, 0, "load_sp_sr_pre");
      ex(0, b, 321, F_SPE, 0, "sp_eval");
      ex(0, b, 342, F_NT, 1, "fetch_nt"); ex(0, b, 342, F_PX, 1, "px_en"); ex(0, b, 342, F_SR, 0, "load_sr");
      ex(0, b, 342, F_VIS, 1, "vis_line"); ex(0, b, 343, F_NT, 0, "fetch_nt");
      ex(0, b, 344, F_AT, 1, "fetch_at"); ex(0, b, 346, F_P0, 1, "fetch_pat0");
      ex(0, b, 348, F_P1, 1, "fetch_pat1"); ex(0, b, 349, F_CX, 1, "inc_cx");
      ex(0, b, 350, F_SR, 1, "load_sr"); ex(0, b, 350, F_NT, 1, "fetch_nt");
      ex(0, b, 597, F_IY, 1, "inc_y"); ex(0, b, 597, F_CX, 1, "inc_cx"); ex(0, b, 597, F_PX, 1, "px_en");
      ex(0, b, 598, F_CPX, 1, "copy_x"); ex(0, b, 598, F_SR, 1, "load_sr"); ex(0, b, 598, F_SPE, 1, "sp_eval");
      ex(0, b, 598, F_PX, 0, "px_en"); ex(0, b, 598, F_NT, 0, "fetch_nt");
      ex(0, b, 661, F_LSP, 1, "load_sp_sr"); ex(0, b, 662, F_NT, 1, "fetch_nt"); ex(0, b, 662, F_SPE, 0, "sp_eval");
      ex(0, b, 677, F_CX, 1, "inc_cx"); ex(0, b, 678, F_SR, 1, "load_sr");
      ex(0, b, 679, F_NT, 0, "fetch_nt"); ex(0, b, 679, F_SR, 0, "load_sr");
      ex(0, b, 1001, F_SCN, 1, "scan_nf_ignored"); ex(0, b, 1001, F_CYC, 319, "cycle_nf_ignored");
      ex(0, b, 1706, F_NT, 0, "fetch_nt_post"); ex(0, b, 1706, F_PX, 0, "px_en_post");
      ex(0, b, 2727, F_SCN, 6, "scan"); ex(0, b, 2727, F_CYC, 340, "cycle"); ex(0, b, 2727, F_ODD, 1, "odd");
      ex(0, b, 2728, F_VB, 1, "vblank"); ex(0, b, 2729, F_VB, 0, "vblank");
      ex(0, b, 3067, F_SCN, 511, "scan"); ex(0, b, 3067, F_CYC, 339, "cycle"); ex(0, b, 3067, F_ODD, 1, "odd");
      ex(0, b, 3068, F_SCN, 0, "scan_skip"); ex(0, b, 3068, F_CYC, 0, "cycle_skip"); ex(0, b, 3068, F_ODD, 0, "odd");
      ex(0, b, 5797, F_NT, 0, "fetch_nt_gated"); ex(0, b, 5797, F_PX, 1, "px_en_gated");
      ex(0, b, 5799, F_AT, 1, "fetch_at_regated");
      ex(0, b, 8522, F_ODD, 1, "odd"); ex(0, b, 8522, F_CYC, 339, "cycle");
      ex(0, b, 8523, F_SCN, 511, "scan_noskip"); ex(0, b, 8523, F_CYC, 340, "cycle_noskip");
      ex(0, b, 8524, F_SCN, 0, "scan"); ex(0, b, 8524, F_CYC, 0, "cycle"); ex(0, b, 8524, F_ODD, 0, "odd");
      ex(1, b, 2046, F_VB, 0, "vblank"); ex(1, b, 3750, F_SCN, 9, "scan"); ex(1, b, 3750, F_CYC, 340, "cycle");
      ex(1, b, 3751, F_SCN, 511, "scan"); ex(1, b, 3751, F_CYC, 0, "cycle"); ex(1, b, 3751, F_VB, 1, "vblank");
      ex(1, b, 3752, F_VB, 0, "vblank"); ex(1, b, 4091, F_SCN, 511, "scan_noskip");
      ex(1, b, 4091, F_CYC, 340, "cycle_noskip"); ex(1, b, 4092, F_SCN, 0, "scan"); ex(1, b, 4092, F_ODD, 0, "odd");
      ex(1, b, 7502, F_SCN, 511, "scan"); ex(1, b, 7502, F_CYC, 0, "cycle");
      vq[0].push_back(b + 2047); vq[0].push_back(b + 4774);
      vq[0].push_back(b + 7502); vq[0].push_back(b + 10230);
      vq[1].push_back(b + 2047); vq[1].push_back(b + 5798); vq[1].push_back(b + 9549);
      wait_to(b + 1000); new_frame = 1'b1;
      wait_to(b + 1001); new_frame = 1'b0;
      wait_to(b + 5797); rend_en = 1'b0;
      wait_to(b + 5798); rend_en = 1'b1;
      wait_to(b + 8522); rend_en = 1'b0;
      wait_to(b + 8523); rend_en = 1'b1;
      wait_to(b + 10300);
      // Phase C: external-trigger instance; the others are parked in reset
      rst = 1'b1;
      @(posedge clk); #1; rst_e = 1'b0; ee = tick;
      ex(2, ee, 0, F_CYC, 0, "cycle"); ex(2, ee, 0, F_SCN, 511, "scan"); ex(2, ee, 0, F_ODD, 0, "odd");
      ex(2, ee, 0, F_VB, 0, "vblank"); ex(2, ee, 341, F_ODD, 1, "odd"); ex(2, ee, 341, F_SCN, 0, "scan");
      ex(2, ee, 2727, F_SCN, 6, "scan"); ex(2, ee, 2727, F_CYC, 340, "cycle");
      ex(2, ee, 2728, F_SCN, 6, "scan_hold"); ex(2, ee, 2728, F_CYC, 0, "cycle_hold");
      ex(2, ee, 3751, F_SCN, 6, "scan_hold"); ex(2, ee, 3751, F_VB, 1, "vblank_hold");
      ex(2, ee, 3760, F_SCN, 6, "scan"); ex(2, ee, 3760, F_CYC, 9, "cycle");
      ex(2, ee, 3761, F_SCN, 511, "scan_trig"); ex(2, ee, 3761, F_CYC, 0, "cycle_trig");
      ex(2, ee, 3761, F_VB, 1, "vblank_trig"); ex(2, ee, 3761, F_ODD, 1, "odd");
      ex(2, ee, 3762, F_VB, 0, "vblank"); ex(2, ee, 3762, F_CYC, 1, "cycle");
      ex(2, ee, 4102, F_SCN, 0, "scan"); ex(2, ee, 4102, F_ODD, 0, "odd");
      ex(2, ee, 4493, F_SCN, 1, "scan"); ex(2, ee, 4493, F_CYC, 50, "cycle");
      ex(2, ee, 4494, F_SCN, 511, "scan_trig_mid"); ex(2, ee, 4494, F_CYC, 0, "cycle_trig_mid");
      ex(2, ee, 4835, F_ODD, 1, "odd"); ex(2, ee, 4935, F_CYC, 100, "cycle"); ex(2, ee, 4935, F_SCN, 0, "scan");
      vq[2].push_back(ee + 2047);
      wait_to(ee + 3760); new_frame = 1'b1;
      wait_to(ee + 3761); new_frame = 1'b0;
      wait_to(ee + 4493); new_frame = 1'b1;
      wait_to(ee + 4494); new_frame = 1'b0;
      wait_to(ee + 4935); rst_e = 1'b1;
      @(posedge clk); #1; rst_e = 1'b0; e2 = tick;
      ex(2, e2, 0, F_CYC, 0, "cycle_rst"); ex(2, e2, 0, F_SCN, 511, "scan_rst");
      ex(2, e2, 0, F_ODD, 0, "odd_rst"); ex(2, e2, 0, F_PRE, 1, "prerender_rst");
      wait_to(e2 + 5);
      foreach (sb[i]) begin
         n_vec++; n_err++;
         $display("FAIL %s never checked, expected %0d", sb[i].nm, sb[i].v);
      end
      for (int d = 0; d < 3; d++) begin
         foreach (vq[d][i]) begin
            n_vec++; n_err++;
            $display("FAIL vset_missing dut%0d got no pulse expected tick %0d", d, vq[d][i]);
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
